// File: rtl/miriscv_lsu_ram.sv
// miriscv_lsu_ram: byte-addressed data RAM, req/ready/valid handshake.
// Optional MIRISCV_RAM_BOUNDS_EN: addresses >= 4*DEPTH return an error.
module miriscv_lsu_ram #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 1,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_ready_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_data_o,
  output logic        mem_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam bit ZL = (LATENCY == 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        we_q;
  logic [2:0]  size_q;

  logic [31:0] mem [DEPTH];

  logic [31:0] c_addr;
  logic [31:0] c_data;
  logic        c_we;
  logic [2:0]  c_size;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wdat;
  logic        err_c;
  logic        oob;
  logic [31:0] rword;
  logic [31:0] rsh;
  logic [31:0] rext;
  logic [31:0] rdata;
  logic        accept;
  logic        commit;

  assign accept = mem_req_i && mem_ready_o;
  assign commit = ZL ? accept
                     : (state == WAIT && cnt == 4'd0);

  // With zero latency the commit happens on the accept edge itself,
  // so the request fields come straight from the inputs.
  assign c_addr = ZL ? mem_addr_i : addr_q;
  assign c_data = ZL ? mem_data_i : data_q;
  assign c_we   = ZL ? mem_we_i   : we_q;
  assign c_size = ZL ? mem_size_i : size_q;

  assign idx  = c_addr[AW+1:2];
  assign lane = c_addr[1:0];

`ifdef MIRISCV_RAM_BOUNDS_EN
  assign oob = |c_addr[31:AW+2];
`else
  logic unused_hi;
  assign oob = 1'b0;
  assign unused_hi = ^c_addr[31:AW+2];
`endif

  // Size/alignment decode: byte enables, lane-replicated data, error.
  always_comb begin
    be    = 4'b0000;
    wdat  = '0;
    err_c = 1'b0;
    unique case (c_size)
      3'd0: begin
        be   = 4'b0001 << lane;
        wdat = {4{c_data[7:0]}};
      end
      3'd4: begin
        err_c = c_we;
      end
      3'd1, 3'd5: begin
        err_c = c_addr[0] || (c_we && c_size[2]);
        be    = c_addr[1] ? 4'b1100 : 4'b0011;
        wdat  = {2{c_data[15:0]}};
      end
      3'd2: begin
        err_c = (lane != 2'b00);
        be    = 4'b1111;
        wdat  = c_data;
      end
      default: begin
        err_c = 1'b1;
      end
    endcase
    if (oob) begin
      err_c = 1'b1;
    end
  end

  assign rword = mem[idx];
  assign rsh   = rword >> {lane, 3'b000};

  // Load extension: sizes 0/1 sign-extend, 4/5 zero-extend.
  always_comb begin
    rext = '0;
    unique case (c_size)
      3'd0:    rext = {{24{rsh[7]}}, rsh[7:0]};
      3'd1:    rext = {{16{rsh[15]}}, rsh[15:0]};
      3'd2:    rext = rword;
      3'd4:    rext = {24'b0, rsh[7:0]};
      3'd5:    rext = {16'b0, rsh[15:0]};
      default: rext = '0;
    endcase
  end

  assign rdata = (err_c || c_we) ? '0 : rext;

  // Handshake FSM; every output is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= 3'd0;
      mem_ready_o <= 1'b1;
      mem_valid_o <= 1'b0;
      mem_data_o  <= '0;
      mem_err_o   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          mem_valid_o <= 1'b0;
          if (accept) begin
            addr_q      <= mem_addr_i;
            data_q      <= mem_data_i;
            we_q        <= mem_we_i;
            size_q      <= mem_size_i;
            mem_ready_o <= 1'b0;
            if (ZL) begin
              state       <= RESP;
              mem_valid_o <= 1'b1;
              mem_data_o  <= rdata;
              mem_err_o   <= err_c;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state       <= RESP;
            mem_valid_o <= 1'b1;
            mem_data_o  <= rdata;
            mem_err_o   <= err_c;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state       <= IDLE;
          mem_valid_o <= 1'b0;
          mem_ready_o <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          mem_valid_o <= 1'b0;
          mem_ready_o <= 1'b1;
        end
      endcase
    end
  end

  // Byte-lane store on the commit edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset_n && commit && c_we && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdat[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_miriscv_lsu_ram.sv
// tb_miriscv_lsu_ram: vector table + scoreboard bench.
// Build with MIRISCV_RAM_BOUNDS_EN to cover the bounds option.
module tb_miriscv_lsu_ram;

  localparam int LAT = 1;

  logic        clk;
  logic        reset_n;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [2:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic        mem_ready_o;
  logic        mem_valid_o;
  logic [31:0] mem_data_o;
  logic        mem_err_o;

  miriscv_lsu_ram #(
    .DEPTH(256),
    .LATENCY(LAT),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_req_i(mem_req_i),
    .mem_we_i(mem_we_i),
    .mem_size_i(mem_size_i),
    .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i),
    .mem_ready_o(mem_ready_o),
    .mem_valid_o(mem_valid_o),
    .mem_data_o(mem_data_o),
    .mem_err_o(mem_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] edata;
    logic        eerr;
    logic        chk;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk;
    int          id;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk32(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic we,
                              input logic [2:0] sz,
                              input logic [31:0] a,
                              input logic [31:0] wd,
                              input logic [31:0] ed,
                              input logic ee,
                              input logic ck);
    vec_t v;
    v.we = we; v.size = sz; v.addr = a;
    v.wdata = wd; v.edata = ed;
    v.eerr = ee; v.chk = ck;
    tv.push_back(v);
  endfunction

  always @(negedge clk) begin
    if (reset_n && mem_valid_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got 1 want 0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk32($sformatf("err#%0d", e.id),
              {31'b0, mem_err_o}, {31'b0, e.err});
        if (e.chk) begin
          chk32($sformatf("data#%0d", e.id),
                mem_data_o, e.data);
        end
      end
    end
  end

  task automatic issue(input vec_t v, input int id);
    int n;
    exp_t e;
    @(negedge clk);
    chk32($sformatf("ready#%0d", id),
          {31'b0, mem_ready_o}, 32'd1);
    mem_req_i  = 1'b1;
    mem_we_i   = v.we;
    mem_size_i = v.size;
    mem_addr_i = v.addr;
    mem_data_i = v.wdata;
    e.data = v.edata; e.err = v.eerr;
    e.chk = v.chk; e.id = id;
    sb.push_back(e);
    @(posedge clk);
    #1 mem_req_i = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (mem_valid_o) break;
    end
    chk32($sformatf("latency#%0d", id), n, LAT + 1);
  endtask

  task automatic chk_reset(input string tag);
    chk32({tag, "_ready"}, {31'b0, mem_ready_o}, 32'd1);
    chk32({tag, "_valid"}, {31'b0, mem_valid_o}, 32'd0);
    chk32({tag, "_data"}, mem_data_o, 32'd0);
    chk32({tag, "_err"}, {31'b0, mem_err_o}, 32'd0);
  endtask

  initial begin
    vec_t v;
    int acc;
    logic [31:0] alias_exp;
`ifdef MIRISCV_RAM_BOUNDS_EN
    logic oob_err = 1'b1;
    alias_exp = 32'h1111_1111;
`else
    logic oob_err = 1'b0;
    alias_exp = 32'hCAFE_BABE;
`endif
    add(1, 2, 32'h10, 32'h8000_00F0, 0, 0, 0);
    add(0, 2, 32'h10, 0, 32'h8000_00F0, 0, 1);
    add(1, 0, 32'h13, 32'h0000_00AB, 0, 0, 0);
    add(0, 0, 32'h13, 0, 32'hFFFF_FFAB, 0, 1);
    add(0, 4, 32'h13, 0, 32'h0000_00AB, 0, 1);
    add(0, 2, 32'h10, 0, 32'hAB00_00F0, 0, 1);
    add(0, 0, 32'h10, 0, 32'hFFFF_FFF0, 0, 1);
    add(0, 4, 32'h12, 0, 32'h0000_0000, 0, 1);
    add(0, 1, 32'h12, 0, 32'hFFFF_AB00, 0, 1);
    add(0, 5, 32'h12, 0, 32'h0000_AB00, 0, 1);
    add(1, 2, 32'h20, 32'h5566_7788, 0, 0, 0);
    add(1, 1, 32'h22, 32'hDEAD_1234, 0, 0, 0);
    add(0, 1, 32'h22, 0, 32'h0000_1234, 0, 1);
    add(0, 2, 32'h20, 0, 32'h1234_7788, 0, 1);
    add(0, 2, 32'h11, 0, 0, 1, 1);
    add(1, 1, 32'h21, 32'hFFFF, 0, 1, 1);
    add(0, 3, 32'h00, 0, 0, 1, 1);
    add(1, 4, 32'h20, 32'hEE, 0, 1, 1);
    add(1, 5, 32'h20, 32'hEEEE, 0, 1, 1);
    add(0, 7, 32'h20, 0, 0, 1, 1);
    add(0, 2, 32'h20, 0, 32'h1234_7788, 0, 1);
    add(1, 2, 32'h00, 32'h1111_1111, 0, 0, 0);
    add(1, 2, 32'h400, 32'hCAFE_BABE, 0, oob_err, oob_err);
    add(0, 2, 32'h00, 0, alias_exp, 0, 1);
    add(1, 2, 32'h30, 32'h0BAD_F00D, 0, 0, 0);
    add(0, 2, 32'h30, 0, 32'h0BAD_F00D, 0, 1);

    reset_n = 1'b0;
    mem_req_i = 1'b0;
    mem_we_i = 1'b0;
    mem_size_i = 3'd0;
    mem_addr_i = '0;
    mem_data_i = '0;
    #12;
    chk_reset("rst");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      issue(tv[i], i);
    end

    // Request held high: one accept every LAT+2 cycles.
    @(negedge clk);
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_size_i = 3'd2;
    mem_addr_i = 32'h20;
    acc = 0;
    for (int c = 0; c < 9; c++) begin
      if (mem_ready_o) begin
        exp_t e;
        e.data = 32'h1234_7788; e.err = 0;
        e.chk = 1; e.id = 100 + acc;
        sb.push_back(e);
        acc++;
      end
      if (mem_valid_o && mem_ready_o) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ready_in_resp: got 1 want 0");
      end
      @(negedge clk);
    end
    mem_req_i = 1'b0;
    chk32("held_accepts", acc, 3);
    repeat (4) @(negedge clk);

    // Reset while a store waits: nothing is written.
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b1;
    mem_size_i = 3'd2;
    mem_addr_i = 32'h30;
    mem_data_i = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 mem_req_i = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk_reset("wait_rst");
    @(negedge clk);
    reset_n = 1'b1;
    v.we = 0; v.size = 2; v.addr = 32'h30;
    v.wdata = 0; v.edata = 32'h0BAD_F00D;
    v.eerr = 0; v.chk = 1;
    issue(v, 200);

    repeat (4) @(negedge clk);
    chk32("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "timeout");
  end

endmodule
